// File: rtl/uart_programmer.sv
// UART boot loader: receives a 16-bit word count, then little-endian 32-bit words, and writes them to RAM.
// Optional inter-byte timeout is enabled by defining UPG_TIMEOUT_EN.
module uart_programmer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_n_i,
  input  logic        upg_rx_i,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam logic [9:0] BIT_END  = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF_END = 10'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1023) begin : g_bad_cpb
    $error("CLKS_PER_BIT out of range 4..1023");
  end
  if (TIMEOUT_CLKS < 1) begin : g_bad_to
    $error("TIMEOUT_CLKS must be positive");
  end

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    DONE
  } ld_state_t;

  rx_state_t   rx_state, rx_next;
  ld_state_t   ld_state, ld_next;

  logic        sync1, rx_s, rx_prev;
  logic [9:0]  cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        stop_wait;
  logic        byte_valid;
  logic        frame_err;
  logic        timeout;

  logic [13:0] n_words;
  logic [13:0] word_adr;
  logic [1:0]  byte_idx;
  logic [31:0] dat_asm;
  logic        last_word;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= upg_rx_i;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) rx_state <= RX_IDLE;
    else              rx_state <= rx_next;
  end

  // Receiver next-state, byte strobe and framing-error decode.
  always_comb begin
    rx_next    = rx_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) rx_next = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_END) rx_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (cnt == BIT_END && bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (stop_wait) begin
          if (rx_s) rx_next = RX_IDLE;
        end else if (cnt == BIT_END) begin
          if (rx_s) begin
            byte_valid = 1'b1;
            rx_next    = RX_IDLE;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
    endcase
  end

  // Receiver bit timing and data shift register.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_wait <= 1'b0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          stop_wait <= 1'b0;
        end
        RX_START: begin
          cnt <= (cnt == HALF_END) ? '0 : cnt + 10'd1;
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        RX_STOP: begin
          if (!stop_wait) begin
            if (cnt == BIT_END) begin
              cnt       <= '0;
              stop_wait <= frame_err;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef UPG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] to_cnt;
  logic          to_active;

  assign to_active = (ld_state == HDR1) || (ld_state == PAYLOAD);
  assign timeout   = to_active && !byte_valid && (to_cnt == TO_END);

  // Idle-gap counter, cleared by every received byte.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i)                       to_cnt <= '0;
    else if (!to_active || byte_valid || timeout) to_cnt <= '0;
    else                                    to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign last_word = (byte_idx == 2'd3) && (word_adr == n_words - 14'd1);

  // Loader state register.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) ld_state <= HDR0;
    else              ld_state <= ld_next;
  end

  // Loader next-state: header, payload, terminal.
  always_comb begin
    ld_next = ld_state;
    unique case (ld_state)
      HDR0: begin
        if (byte_valid) ld_next = HDR1;
      end
      HDR1: begin
        if (byte_valid)
          ld_next = ({shreg[5:0], n_words[7:0]} == 14'd0) ? DONE : PAYLOAD;
      end
      PAYLOAD: begin
        if (byte_valid && last_word) ld_next = DONE;
      end
      DONE: ld_next = DONE;
    endcase
    if (timeout) ld_next = HDR0;
  end

  // Loader datapath: word count, assembly, write strobe and flags.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      n_words    <= '0;
      word_adr   <= '0;
      byte_idx   <= '0;
      dat_asm    <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
    end else begin
      upg_wen_o  <= 1'b0;
      upg_done_o <= (ld_state == DONE);
      upg_err_o  <= upg_err_o | frame_err | timeout;
      if (timeout) begin
        word_adr <= '0;
        byte_idx <= '0;
      end else if (byte_valid) begin
        unique case (ld_state)
          HDR0: n_words[7:0] <= shreg;
          HDR1: begin
            n_words[13:8] <= shreg[5:0];
            word_adr      <= '0;
            byte_idx      <= '0;
          end
          PAYLOAD: begin
            dat_asm  <= {shreg, dat_asm[31:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= word_adr;
              upg_dat_o <= {shreg, dat_asm[31:8]};
              word_adr  <= word_adr + 14'd1;
            end
          end
          DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_programmer.sv
// Self-checking bench for uart_programmer.
// Scoreboard of expected RAM writes, checked on every write strobe.
module tb_uart_programmer;

  localparam int CPB = 8;
  localparam int TO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wen;
  logic [13:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [13:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  uart_programmer #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .upg_clk_i  (clk),
    .upg_rst_n_i(rst_n),
    .upg_rx_i   (rx),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wen adr=%0h dat=%h required no write", adr, dat);
      end else begin
        mon_e = exp_q.pop_front();
        if (adr !== mon_e.adr || dat !== mon_e.dat) begin
          failures++;
          $display("FAIL wen_data adr=%0h dat=%h required adr=%0h dat=%h",
                   adr, dat, mon_e.adr, mon_e.dat);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_early done=%b required 0 during strobe", done);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic push(input logic [13:0] a, input logic [31:0] d);
    wr_t e;
    e.adr = a;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (wen !== 1'b0) begin failures++; $display("FAIL rst_wen got=%b required 0", wen); end
    if (adr !== 14'd0) begin failures++; $display("FAIL rst_adr got=%0h required 0", adr); end
    if (dat !== 32'd0) begin failures++; $display("FAIL rst_dat got=%h required 0", dat); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b required 0", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b required 0", err); end
  endtask

  task automatic test_two_words();
    do_reset();
    push(14'd0, 32'h1234_5678);
    push(14'd1, 32'hDEAD_BEEF);
    send_hdr(16'h0002);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    wait_drain("two_words");
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL two_done got=%b required 1", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL two_err got=%b required 0", err); end
    if (adr !== 14'd1) begin failures++; $display("FAIL two_adr_hold got=%0h required 1", adr); end
    if (dat !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL two_dat_hold got=%h required deadbeef", dat);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_hdr(16'h0000);
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b required 1", done); end
    send_byte(8'h55, 1'b1);
    wait_drain("zero");
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL zero_err got=%b required 0", err); end
  endtask

  task automatic test_framing();
    do_reset();
    push(14'd0, 32'hDDCC_BBAA);
    send_hdr(16'h0001);
    send_byte(8'h77, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL frame_err got=%b required 1", err); end
    send_word(32'hDDCC_BBAA);
    wait_drain("frame");
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL frame_done got=%b required 1", done); end
    if (err !== 1'b1) begin failures++; $display("FAIL frame_err_sticky got=%b required 1", err); end
  endtask

  task automatic test_glitch();
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b required 0", err); end
    send_hdr(16'h0000);
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL glitch_done got=%b required 1 (glitch taken as byte)", done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_hdr(16'h0002);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    do_reset();
    push(14'd0, 32'h4433_2211);
    send_hdr(16'h0001);
    send_word(32'h4433_2211);
    wait_drain("reset_mid");
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b required 1", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b required 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    send_hdr(16'hC003);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      push(14'(i), w);
      send_word(w);
    end
    wait_drain("b2b");
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b required 1", done); end
    if (adr !== 14'd2) begin failures++; $display("FAIL b2b_adr got=%0h required 2", adr); end
  endtask

`ifdef UPG_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_hdr(16'h0001);
    send_byte(8'h99, 1'b1);
    send_byte(8'h98, 1'b1);
    repeat (TO + 50) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%b required 1", err); end
    push(14'd0, 32'h0403_0201);
    send_hdr(16'h0001);
    send_word(32'h0403_0201);
    wait_drain("timeout");
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL to_done got=%b required 1", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_reset();
    test_zero_count();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
`ifdef UPG_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
